inst_rom_loader: RTL and testbench
==================================

// Module: inst_rom_loader
// PURPOSE
// - Responder end of the core's instruction fetch port: answers rom_ce/rom_addr with a 32-bit instruction word in the same cycle.
// - Also owns a byte-serial program load port (valid/ready) that packs little-endian bytes into words and writes them sequentially from word 0.
// - Sits beside rv32 core in the SoC top; the load port is driven by the boot loader or the bench.
// PARAMETERS
// - DEPTH     1024            number of 32-bit words
// - ADDR_W    10              log2(DEPTH); word index width
// - NOP_INST  32'h00000013    word returned when fetch is disabled or rejected (addi x0,x0,0)
// PORTS
// - clk_i        in   1         clock, rising edge
// - rst_i        in   1         reset, asynchronous, active-low
// - rom_ce_i     in   1         fetch enable from core
// - rom_addr_i   in   32        fetch byte address (pc)
// - rom_data_o   out  32        fetched instruction, combinational
// - rom_err_o    out  1         sticky fetch-error flag
// - ld_start_i   in   1         pulse: restart load at word 0
// - ld_end_i     in   1         pulse: finish load, flush partial word
// - ld_valid_i   in   1         load byte valid
// - ld_data_i    in   8         load byte
// - ld_ready_o   out  1         load byte accepted when valid&ready at clock edge
// - ld_words_o   out  ADDR_W+1  words written since last ld_start_i
// BEHAVIOUR
// - Reset (rst_i=0, async): state=S_IDLE, ld_ready_o=0, ld_words_o=0, byte_cnt=0, word buffer=0, rom_err_o=0. Memory array is not reset.
// - Fetch: rom_ce_i=0 -> rom_data_o=32'h0. rom_ce_i=1 -> rom_data_o=mem[rom_addr_i[ADDR_W+1:2]], zero latency.
// - Fetch of a word being written on the same edge returns the old contents; the new value is visible the next cycle.
// - FSM states: S_IDLE, S_LOAD, S_FULL. ld_ready_o is 1 only in S_LOAD and is registered.
// - ld_start_i in any state: wptr=0, byte_cnt=0, buffer=0, ld_words_o=0, next state S_LOAD. A byte presented in the same cycle is discarded.
// - S_LOAD, valid&ready: write ld_data_i to buffer lane byte_cnt (bits 8*byte_cnt+7:8*byte_cnt), then byte_cnt++.
//   - On the 4th byte (byte_cnt==3), write the assembled word to mem[wptr] on that same edge, then wptr++, ld_words_o++, byte_cnt=0, buffer=0.
//   - If that write hit wptr==DEPTH-1, go to S_FULL; no wrap.
// - S_LOAD, ld_end_i: if byte_cnt!=0, write the buffer to mem[wptr] with the unfilled upper bytes zero, and increment ld_words_o; then go to S_IDLE.
//   - ld_end_i together with valid&ready: the byte is merged first, then flushed (a 4th byte writes once, no extra word).
// - S_FULL: ld_ready_o=0; further bytes stall. ld_end_i -> S_IDLE. ld_start_i -> S_LOAD.
// - S_IDLE: ld_ready_o=0; ld_end_i ignored.
// - Loading and fetching are independent; the core is normally held in reset during a load.
// - Reset asserted mid-load: FSM and counters clear; words already written stay in the array.
// CONFIGURATION
// - INST_ROM_BOUNDS_CHK_EN defined:
//   - A fetch with rom_ce_i=1 and rom_addr_i[1:0]!=0, or rom_addr_i >= 4*DEPTH, returns NOP_INST instead of the array word.
//   - Such a fetch sets rom_err_o=1 on the next edge; it stays 1 until reset.
// - INST_ROM_BOUNDS_CHK_EN undefined:
//   - rom_addr_i[1:0] and the bits above ADDR_W+1 are ignored, so the index wraps.
//   - rom_err_o is tied to 0.
// TESTING
// - Reset: release rst_i with no activity -> ld_ready_o=0, ld_words_o=0, rom_err_o=0; rom_ce_i=0 -> rom_data_o=0.
// - Load: ld_start_i, then bytes 13,05,10,00, 93,00,20,00, ld_end_i -> ld_words_o=2;
//   fetch addr 0 -> 32'h00100513, addr 4 -> 32'h00200093, same cycle as rom_ce_i.
// - Partial word: ld_start_i, bytes AA,BB, ld_end_i -> ld_words_o=1, mem[0]=32'h0000BBAA; FSM returns to S_IDLE, ld_ready_o=0.
// - Full: DEPTH=4; load 17 bytes -> ld_ready_o=0 after the 16th byte, ld_words_o=4, 17th byte held;
//   ld_start_i -> ld_ready_o=1, ld_words_o=0.
// - Reset mid-word: 2 bytes in, pull rst_i low -> ld_words_o=0, S_IDLE; earlier full words still readable.
// - Bounds (INST_ROM_BOUNDS_CHK_EN set, DEPTH=1024): fetch 32'h00001000 or 32'h00000002 -> rom_data_o=32'h00000013, rom_err_o=1 next cycle and held;
//   with the macro unset, fetch 32'h00001000 -> mem[0], rom_err_o=0.

Source files
------------

// File: rtl/inst_rom_loader.sv
// inst_rom_loader
// Instruction memory for the rv32 core: a zero-latency fetch port plus a
// byte-serial load port that packs little-endian bytes into 32-bit words and
// writes them sequentially from word 0.
// Optional build macro: INST_ROM_BOUNDS_CHK_EN enables fetch address checking
// (misaligned or out-of-range fetches return NOP_INST and raise a sticky
// error flag). Without it the fetch index simply wraps.
module inst_rom_loader #(
   parameter int          DEPTH    = 1024,
   parameter int          ADDR_W   = $clog2(DEPTH),
   parameter logic [31:0] NOP_INST = 32'h00000013
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              rom_ce_i,
   input  logic [31:0]       rom_addr_i,
   output logic [31:0]       rom_data_o,
   output logic              rom_err_o,
   input  logic              ld_start_i,
   input  logic              ld_end_i,
   input  logic              ld_valid_i,
   input  logic [7:0]        ld_data_i,
   output logic              ld_ready_o,
   output logic [ADDR_W:0]   ld_words_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_FULL = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

   logic [31:0]       r_mem [DEPTH];

   state_t            r_state;
   logic              r_ready;
   logic [1:0]        r_byteCnt;
   logic [31:0]       r_buf;
   logic [ADDR_W-1:0] r_wptr;
   logic [ADDR_W:0]   r_words;

   state_t            w_nextState;
   logic [1:0]        w_nextCnt;
   logic [31:0]       w_nextBuf;
   logic [ADDR_W-1:0] w_nextWptr;
   logic [ADDR_W:0]   w_nextWords;
   logic [31:0]       w_mergedBuf;
   logic              w_accept;
   logic              w_wrEn;

   logic [ADDR_W-1:0] w_fetchIdx;
   logic [31:0]       w_arrayWord;

   assign w_fetchIdx  = rom_addr_i[ADDR_W+1:2];
   assign w_arrayWord = r_mem[w_fetchIdx];
   assign ld_ready_o  = r_ready;
   assign ld_words_o  = r_words;

   // Load FSM next-state logic: a restart wins over everything, then byte merge, then flush on end.
   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_byteCnt;
      w_nextBuf   = r_buf;
      w_nextWptr  = r_wptr;
      w_nextWords = r_words;
      w_mergedBuf = r_buf;
      w_accept    = 1'b0;
      w_wrEn      = 1'b0;
      if (ld_start_i) begin
         w_nextState = S_LOAD;
         w_nextCnt   = 2'd0;
         w_nextBuf   = 32'h0;
         w_nextWptr  = '0;
         w_nextWords = '0;
      end else begin
         case (r_state)
            S_LOAD: begin
               w_accept = ld_valid_i && r_ready;
               if (w_accept) begin
                  case (r_byteCnt)
                     2'd0:    w_mergedBuf[7:0]   = ld_data_i;
                     2'd1:    w_mergedBuf[15:8]  = ld_data_i;
                     2'd2:    w_mergedBuf[23:16] = ld_data_i;
                     default: w_mergedBuf[31:24] = ld_data_i;
                  endcase
                  if (r_byteCnt == 2'd3) begin
                     w_wrEn      = 1'b1;
                     w_nextWptr  = r_wptr + 1'b1;
                     w_nextWords = r_words + 1'b1;
                     w_nextCnt   = 2'd0;
                     w_nextBuf   = 32'h0;
                     if (r_wptr == LAST_WORD) begin
                        w_nextState = S_FULL;
                     end
                  end else begin
                     w_nextCnt = r_byteCnt + 1'b1;
                     w_nextBuf = w_mergedBuf;
                  end
               end
               if (ld_end_i) begin
                  if (w_nextCnt != 2'd0) begin
                     w_wrEn      = 1'b1;
                     w_nextWptr  = r_wptr + 1'b1;
                     w_nextWords = r_words + 1'b1;
                  end
                  w_nextCnt   = 2'd0;
                  w_nextBuf   = 32'h0;
                  w_nextState = S_IDLE;
               end
            end
            S_FULL: begin
               if (ld_end_i) begin
                  w_nextState = S_IDLE;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Load FSM state and counters; ready is registered from the next state.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state   <= S_IDLE;
         r_ready   <= 1'b0;
         r_byteCnt <= 2'd0;
         r_buf     <= 32'h0;
         r_wptr    <= '0;
         r_words   <= '0;
      end else begin
         r_state   <= w_nextState;
         r_ready   <= (w_nextState == S_LOAD);
         r_byteCnt <= w_nextCnt;
         r_buf     <= w_nextBuf;
         r_wptr    <= w_nextWptr;
         r_words   <= w_nextWords;
      end
   end

   // Word array write; contents survive reset so a reset mid-load keeps finished words.
   always_ff @(posedge clk_i) begin
      if (w_wrEn) begin
         r_mem[r_wptr] <= w_mergedBuf;
      end
   end

`ifdef INST_ROM_BOUNDS_CHK_EN
   localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

   logic w_badFetch;
   logic r_err;

   assign w_badFetch = rom_ce_i && ((rom_addr_i[1:0] != 2'b00) || (rom_addr_i >= ADDR_LIMIT));
   assign rom_err_o  = r_err;

   // Fetch mux: disabled reads give zero, rejected reads give a harmless NOP.
   always_comb begin
      rom_data_o = 32'h0;
      if (rom_ce_i) begin
         rom_data_o = w_badFetch ? NOP_INST : w_arrayWord;
      end
   end

   // Sticky fetch-error flag, cleared only by reset.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_err <= 1'b0;
      end else if (w_badFetch) begin
         r_err <= 1'b1;
      end
   end
`else
   logic w_unusedAddrBits;

   assign w_unusedAddrBits = ^{rom_addr_i[31:ADDR_W+2], rom_addr_i[1:0]};
   assign rom_err_o        = 1'b0;

   // Fetch mux: disabled reads give zero, otherwise the wrapped array word.
   always_comb begin
      rom_data_o = 32'h0;
      if (rom_ce_i) begin
         rom_data_o = w_arrayWord;
      end
   end
`endif

endmodule

// File: tb/tb_inst_rom_loader.sv
// tb_inst_rom_loader
// Directed bench for inst_rom_loader: one full-size instance and one
// four-word instance for the full-array case. Expected values follow the
// INST_ROM_BOUNDS_CHK_EN setting of the build.
module tb_inst_rom_loader;

   logic        clk;
   logic        rst_n;

   // full-size instance signals
   logic        mCe;
   logic [31:0] mAddr;
   logic [31:0] mData;
   logic        mErr;
   logic        mStart;
   logic        mEnd;
   logic        mValid;
   logic [7:0]  mByte;
   logic        mReady;
   logic [10:0] mWords;

   // four-word instance signals
   logic        sCe;
   logic [31:0] sAddr;
   logic [31:0] sData;
   logic        sErr;
   logic        sStart;
   logic        sEnd;
   logic        sValid;
   logic [7:0]  sByte;
   logic        sReady;
   logic [2:0]  sWords;

   int errors;
   int checks;

   inst_rom_loader dutMain (
      .clk_i      (clk),
      .rst_i      (rst_n),
      .rom_ce_i   (mCe),
      .rom_addr_i (mAddr),
      .rom_data_o (mData),
      .rom_err_o  (mErr),
      .ld_start_i (mStart),
      .ld_end_i   (mEnd),
      .ld_valid_i (mValid),
      .ld_data_i  (mByte),
      .ld_ready_o (mReady),
      .ld_words_o (mWords)
   );

   inst_rom_loader #(
      .DEPTH  (4),
      .ADDR_W (2)
   ) dutSmall (
      .clk_i      (clk),
      .rst_i      (rst_n),
      .rom_ce_i   (sCe),
      .rom_addr_i (sAddr),
      .rom_data_o (sData),
      .rom_err_o  (sErr),
      .ld_start_i (sStart),
      .ld_end_i   (sEnd),
      .ld_valid_i (sValid),
      .ld_data_i  (sByte),
      .ld_ready_o (sReady),
      .ld_words_o (sWords)
   );

   // 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      mValid = 1'b1;
      mByte  = b;
      tick();
      mValid = 1'b0;
   endtask

   task automatic sendSmall(input logic [7:0] b);
      sValid = 1'b1;
      sByte  = b;
      tick();
      sValid = 1'b0;
   endtask

   task automatic pulseStart();
      mStart = 1'b1;
      tick();
      mStart = 1'b0;
   endtask

   task automatic pulseEnd();
      mEnd = 1'b1;
      tick();
      mEnd = 1'b0;
   endtask

   // Directed sequence
   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      mCe = 1'b0; mAddr = 32'h0; mStart = 1'b0; mEnd = 1'b0; mValid = 1'b0; mByte = 8'h0;
      sCe = 1'b0; sAddr = 32'h0; sStart = 1'b0; sEnd = 1'b0; sValid = 1'b0; sByte = 8'h0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      $display("[TB] reset state");
      checkOutput("rst_ready", 32'(mReady), 32'h0);
      checkOutput("rst_words", 32'(mWords), 32'h0);
      checkOutput("rst_err", 32'(mErr), 32'h0);
      checkOutput("rst_data_ce0", mData, 32'h0);

      $display("[TB] two-word load");
      pulseStart();
      checkOutput("load_ready", 32'(mReady), 32'h1);
      checkOutput("load_words0", 32'(mWords), 32'h0);
      applyStimulus(8'h13); applyStimulus(8'h05); applyStimulus(8'h10); applyStimulus(8'h00);
      checkOutput("load_words1", 32'(mWords), 32'h1);
      applyStimulus(8'h93); applyStimulus(8'h00); applyStimulus(8'h20); applyStimulus(8'h00);
      pulseEnd();
      checkOutput("load_words2", 32'(mWords), 32'h2);
      checkOutput("load_ready_idle", 32'(mReady), 32'h0);
      mCe = 1'b1; mAddr = 32'h0; #1;
      checkOutput("fetch_w0", mData, 32'h00100513);
      mAddr = 32'h4; #1;
      checkOutput("fetch_w1", mData, 32'h00200093);
      mCe = 1'b0; #1;
      checkOutput("fetch_ce0", mData, 32'h0);

      $display("[TB] partial word flush");
      pulseStart();
      applyStimulus(8'hAA); applyStimulus(8'hBB);
      pulseEnd();
      checkOutput("part_words", 32'(mWords), 32'h1);
      checkOutput("part_ready", 32'(mReady), 32'h0);
      mCe = 1'b1; mAddr = 32'h0; #1;
      checkOutput("part_w0", mData, 32'h0000BBAA);
      mAddr = 32'h4; #1;
      checkOutput("part_w1_kept", mData, 32'h00200093);
      mCe = 1'b0;

      $display("[TB] end together with fourth byte");
      pulseStart();
      applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33);
      mValid = 1'b1; mByte = 8'h44; mEnd = 1'b1;
      tick();
      mValid = 1'b0; mEnd = 1'b0;
      checkOutput("endfull_words", 32'(mWords), 32'h1);
      checkOutput("endfull_ready", 32'(mReady), 32'h0);
      mCe = 1'b1; mAddr = 32'h0; #1;
      checkOutput("endfull_w0", mData, 32'h44332211);
      mAddr = 32'h4; #1;
      checkOutput("endfull_w1_kept", mData, 32'h00200093);
      mCe = 1'b0;

      $display("[TB] restart discards same-cycle byte; write visible next cycle");
      pulseStart();
      mStart = 1'b1; mValid = 1'b1; mByte = 8'h55;
      tick();
      mStart = 1'b0; mValid = 1'b0;
      checkOutput("restart_words", 32'(mWords), 32'h0);
      applyStimulus(8'h01); applyStimulus(8'h02); applyStimulus(8'h03);
      mValid = 1'b1; mByte = 8'h04; mCe = 1'b1; mAddr = 32'h0; #1;
      checkOutput("wr_old_visible", mData, 32'h44332211);
      tick();
      mValid = 1'b0;
      checkOutput("wr_new_visible", mData, 32'h04030201);
      pulseEnd();
      checkOutput("restart_words_end", 32'(mWords), 32'h1);
      mCe = 1'b0;

      $display("[TB] full array on four-word instance");
      sStart = 1'b1;
      tick();
      sStart = 1'b0;
      checkOutput("full_ready_start", 32'(sReady), 32'h1);
      for (int i = 0; i < 12; i++) begin
         sendSmall(8'(i));
      end
      checkOutput("full_ready_12", 32'(sReady), 32'h1);
      checkOutput("full_words_12", 32'(sWords), 32'h3);
      for (int i = 12; i < 16; i++) begin
         sendSmall(8'(i));
      end
      checkOutput("full_ready_16", 32'(sReady), 32'h0);
      checkOutput("full_words_16", 32'(sWords), 32'h4);
      sValid = 1'b1; sByte = 8'hEE;
      tick();
      tick();
      checkOutput("full_stall_ready", 32'(sReady), 32'h0);
      checkOutput("full_stall_words", 32'(sWords), 32'h4);
      sValid = 1'b0;
      sCe = 1'b1; sAddr = 32'h0; #1;
      checkOutput("full_w0", sData, 32'h03020100);
      sAddr = 32'hC; #1;
      checkOutput("full_w3", sData, 32'h0F0E0D0C);
      sCe = 1'b0;
      sStart = 1'b1;
      tick();
      sStart = 1'b0;
      checkOutput("full_restart_ready", 32'(sReady), 32'h1);
      checkOutput("full_restart_words", 32'(sWords), 32'h0);

      $display("[TB] reset mid-word");
      pulseStart();
      applyStimulus(8'h13); applyStimulus(8'h05); applyStimulus(8'h10); applyStimulus(8'h00);
      applyStimulus(8'h77); applyStimulus(8'h88);
      checkOutput("midrst_words_before", 32'(mWords), 32'h1);
      rst_n = 1'b0; #2;
      checkOutput("midrst_words", 32'(mWords), 32'h0);
      checkOutput("midrst_ready", 32'(mReady), 32'h0);
      checkOutput("midrst_small_words", 32'(sWords), 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      checkOutput("midrst_ready_after", 32'(mReady), 32'h0);
      mCe = 1'b1; mAddr = 32'h0; #1;
      checkOutput("midrst_w0_kept", mData, 32'h00100513);
      mAddr = 32'h4; #1;
      checkOutput("midrst_w1_kept", mData, 32'h00200093);
      mAddr = 32'h8; #1;
      checkOutput("midrst_w2_untouched_err", 32'(mErr), 32'h0);

      $display("[TB] fetch bounds");
      mAddr = 32'h00001000; #1;
`ifdef INST_ROM_BOUNDS_CHK_EN
      checkOutput("oob_data", mData, 32'h00000013);
      checkOutput("oob_err_same_cycle", 32'(mErr), 32'h0);
      tick();
      mCe = 1'b0; #1;
      checkOutput("oob_err_next", 32'(mErr), 32'h1);
      tick();
      checkOutput("oob_err_held", 32'(mErr), 32'h1);
      mCe = 1'b1; mAddr = 32'h00000002; #1;
      checkOutput("misalign_data", mData, 32'h00000013);
      tick();
      checkOutput("misalign_err", 32'(mErr), 32'h1);
      mAddr = 32'h00000004; #1;
      checkOutput("inbound_data", mData, 32'h00200093);
      mAddr = 32'h00000FFC; #1;
      tick();
      checkOutput("lastword_err_held", 32'(mErr), 32'h1);
`else
      checkOutput("wrap_data", mData, 32'h00100513);
      tick();
      checkOutput("wrap_err", 32'(mErr), 32'h0);
      mAddr = 32'h00000006; #1;
      checkOutput("lowbits_ignored", mData, 32'h00200093);
      tick();
      checkOutput("lowbits_err", 32'(mErr), 32'h0);
      mAddr = 32'h00001004; #1;
      checkOutput("wrap_w1", mData, 32'h00200093);
`endif
      mCe = 1'b0;
      tick();

      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
